// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with 3-sample majority vote, valid/ready byte register and error pulses; optional parity via UART_RX_PARITY_EN
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 baud_x16_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [2:0] LAST = 3'(DATA_BITS - 1);
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic [3:0] ph;
  logic [2:0] idx;
  logic [DATA_BITS-1:0] sr;
  logic s7, s8, pend, rxs, vote;
`ifdef UART_RX_PARITY_EN
  logic pbad;
`endif
  assign rxs  = sync[SYNC_STAGES-1];
  assign vote = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0 & PARITY_ODD[0];
`endif
  // rx metastability synchronizer, idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '1;
    else sync <= {sync[SYNC_STAGES-2:0], rx};
  end
  // bit-phase FSM: samples at ph 7/8/9, decides each bit at ph 9, advances bits on ph wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      ph        <= 4'd0;
      idx       <= 3'd0;
      sr        <= '0;
      s7        <= 1'b0;
      s8        <= 1'b0;
      pend      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad       <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      pend      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (!en) begin
        state <= IDLE;
        busy  <= 1'b0;
        ph    <= 4'd0;
        idx   <= 3'd0;
      end else if (baud_x16_tick) begin
        ph <= ph + 4'd1;
        if (ph == 4'd7) s7 <= rxs;
        if (ph == 4'd8) s8 <= rxs;
        case (state)
          IDLE: begin
            ph <= 4'd0;
            if (!rxs) begin
              state <= START;
              busy  <= 1'b1;
`ifdef UART_RX_PARITY_EN
              pbad  <= 1'b0;
`endif
            end
          end
          START: begin
            if (ph == 4'd9 && vote) begin
              state <= IDLE;
              busy  <= 1'b0;
              ph    <= 4'd0;
            end else if (ph == 4'd15) begin
              state <= DATA;
              idx   <= 3'd0;
            end
          end
          DATA: begin
            if (ph == 4'd9) sr <= {vote, sr[DATA_BITS-1:1]};
            if (ph == 4'd15) begin
`ifdef UART_RX_PARITY_EN
              if (idx == LAST) state <= PARITY;
`else
              if (idx == LAST) state <= STOP;
`endif
              else idx <= idx + 3'd1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (ph == 4'd9) pbad <= vote != (^sr ^ PARITY_ODD[0]);
            if (ph == 4'd15) state <= STOP;
          end
`endif
          STOP: begin
            if (ph == 4'd9) begin
              state <= IDLE;
              busy  <= 1'b0;
              ph    <= 4'd0;
              if (!vote) frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              else if (pbad) parity_err <= 1'b1;
`endif
              else pend <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            ph    <= 4'd0;
          end
        endcase
      end
    end
  end
  // output register: load a completed byte if free or being consumed, else flag overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (pend && (!data_valid || data_ready)) begin
      data_out   <= sr;
      data_valid <= 1'b1;
      overrun    <= 1'b0;
    end else begin
      overrun <= pend & en;
      if (data_ready) data_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven, hand-sequenced and randomized checks of uart_rx against a frame-level model
module tb_uart_rx;
  localparam logic PODD = 1'b0;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, tick = 1'b0, rx = 1'b1, data_ready = 1'b1;
  logic [7:0] data_out;
  logic data_valid, frame_err, parity_err, overrun, busy;
  int tests = 0, fails = 0, n_fe = 0, n_pe = 0, n_ov = 0, k, fe0, pe0, ov0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       flip;
    int         gb;
    int         exp_v;
    int         exp_fe;
    int         exp_pe;
  } vec_t;
  vec_t vt[$];

  uart_rx dut (
    .clk(clk), .rst_n(rst_n), .en(en), .baud_x16_tick(tick), .rx(rx),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // 16x tick: one clock high out of every four
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  // scoreboard taps: count flag pulses and record every accepted byte
  always @(negedge clk) begin
    if (frame_err) n_fe++;
    if (parity_err) n_pe++;
    if (overrun) n_ov++;
    if (data_valid && data_ready) got.push_back(data_out);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!tick) @(posedge clk);
    end
    #1;
  endtask

  // one bit period; g inverts the line for the single tick that lands on the receiver's ph 8
  task automatic send_bit(input logic b, input logic g);
    rx = b;
    if (g) begin
      ticks(8);
      rx = ~b;
      ticks(1);
      rx = b;
      ticks(7);
    end else ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gb
`ifdef UART_RX_PARITY_EN
    , input logic flip = 1'b0
`endif
  );
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], gb == i);
`ifdef UART_RX_PARITY_EN
    send_bit(^d ^ PODD ^ flip, 1'b0);
`endif
    send_bit(stop, 1'b0);
    rx = 1'b1;
  endtask

  initial begin
    vt.push_back('{8'hA5, 1'b1, 1'b0, -1, 1, 0, 0});
    vt.push_back('{8'h3C, 1'b0, 1'b0, -1, 0, 1, 0});
    vt.push_back('{8'h3C, 1'b1, 1'b0, -1, 1, 0, 0});
    vt.push_back('{8'h00, 1'b1, 1'b0,  3, 1, 0, 0});
    vt.push_back('{8'hFF, 1'b1, 1'b0, -1, 1, 0, 0});
    vt.push_back('{8'h81, 1'b1, 1'b0,  7, 1, 0, 0});
    vt.push_back('{8'h01, 1'b0, 1'b0, -1, 0, 1, 0});
`ifdef UART_RX_PARITY_EN
    vt.push_back('{8'h5A, 1'b1, 1'b1, -1, 0, 0, 1});
    vt.push_back('{8'h5A, 1'b0, 1'b1, -1, 0, 1, 0});
`endif

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {frame_err, parity_err, overrun}, 0);
    rst_n = 1'b1;
    en = 1'b1;
    ticks(20);

    // nominal latency: data_valid rises exactly one clock after busy falls at the stop decision
    k = 0;
    fork
      send_frame(8'hA5, 1'b1, -1);
      begin
        while (!busy && k < 3000) begin @(negedge clk); k++; end
        while (busy && k < 3000) begin @(negedge clk); k++; end
        chk("nom_timeout", k < 3000, 1);
        chk("nom_dv_at_stop_tick", data_valid, 0);
        @(negedge clk);
        chk("nom_dv", data_valid, 1);
        chk("nom_data", data_out, 8'hA5);
      end
    join
    ticks(32);

    // table-driven frames
    foreach (vt[i]) begin
      got.delete();
      fe0 = n_fe;
      pe0 = n_pe;
`ifdef UART_RX_PARITY_EN
      send_frame(vt[i].d, vt[i].stop, vt[i].gb, vt[i].flip);
`else
      send_frame(vt[i].d, vt[i].stop, vt[i].gb);
`endif
      ticks(32);
      chk($sformatf("vec%0d_count", i), got.size(), vt[i].exp_v);
      if (got.size() > 0 && vt[i].exp_v > 0) chk($sformatf("vec%0d_data", i), got[0], vt[i].d);
      chk($sformatf("vec%0d_frame_err", i), n_fe - fe0, vt[i].exp_fe);
      chk($sformatf("vec%0d_parity_err", i), n_pe - pe0, vt[i].exp_pe);
    end

    // false start: 5 ticks low then idle
    got.delete();
    fe0 = n_fe;
    rx = 1'b0;
    ticks(5);
    chk("fs_busy_high", busy, 1);
    rx = 1'b1;
    ticks(16);
    chk("fs_busy_low", busy, 0);
    chk("fs_no_data", got.size() + data_valid, 0);
    chk("fs_no_flags", n_fe - fe0, 0);

    // overrun: two back-to-back frames with the consumer stalled
    got.delete();
    ov0 = n_ov;
    data_ready = 1'b0;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    ticks(32);
    chk("ov_data", data_out, 8'h11);
    chk("ov_valid", data_valid, 1);
    chk("ov_pulse", n_ov - ov0, 1);
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ov_drain_count", got.size(), 1);
    if (got.size() > 0) chk("ov_drain_data", got[0], 8'h11);
    chk("ov_valid_drop", data_valid, 0);
    ticks(20);
    chk("ov_no_reload", data_valid, 0);

    // asynchronous reset in the middle of data bit 4, with a byte pending
    data_ready = 1'b0;
    send_frame(8'h77, 1'b1, -1);
    ticks(8);
    chk("mr_pre_valid", data_valid, 1);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
    rx = 1'b1;
    ticks(8);
    chk("mr_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_outputs", {data_out, data_valid, busy, frame_err, parity_err, overrun}, 0);
    rx = 1'b1;
    ticks(2);
    rst_n = 1'b1;
    data_ready = 1'b1;
    ticks(20);

    // receiver disabled mid-frame, then a clean 0x5A
    got.delete();
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("en_busy_low", busy, 0);
    rx = 1'b1;
    ticks(150);
    en = 1'b1;
    ticks(20);
    chk("en_no_data", got.size() + data_valid, 0);
    send_frame(8'h5A, 1'b1, -1);
    ticks(32);
    chk("en_recv_count", got.size(), 1);
    if (got.size() > 0) chk("en_recv_data", got[0], 8'h5A);

    // randomized frames against the frame-level model
    got.delete();
    exp_q.delete();
    fe0 = n_fe;
    pe0 = n_pe;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      logic stop;
      d = 8'($urandom);
      stop = $urandom_range(0, 4) != 0;
      send_frame(d, stop, int'($urandom_range(0, 8)) - 1);
      if (stop) exp_q.push_back(d);
      ticks(stop ? 16 * int'($urandom_range(0, 2)) : 32);
    end
    ticks(32);
    chk("rnd_count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("rnd_data%0d", i), got[i], exp_q[i]);
    chk("rnd_frame_err", n_fe - fe0, 20 - exp_q.size());
    chk("rnd_parity_err", n_pe - pe0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
